// File: rtl/locker_pkg.sv
// rtl/locker_pkg.sv - shared key codes, widths and state type for the locker keypad front-end
package locker_pkg;

  localparam int DIGIT_W        = 4;
  localparam int DEFAULT_DIGITS = 3;
  localparam int KEY_W          = 5;

  localparam logic [KEY_W-1:0] KEY_CLEAR = 5'h10;
  localparam logic [KEY_W-1:0] KEY_BKSP  = 5'h11;
  localparam logic [KEY_W-1:0] KEY_ENTER = 5'h12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SUBMIT,
    ST_WAIT,
    ST_LOCKED
  } state_t;

  function automatic logic is_digit(input logic [KEY_W-1:0] code);
    return code < 5'h10;
  endfunction

endpackage

// File: rtl/locker_timeout_counter.sv
// rtl/locker_timeout_counter.sv - reloadable inactivity down-counter
// expired flags the last idle cycle of the window so the caller can act on that edge.
module locker_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] RELOAD = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = en && (count == W'(1));

endmodule

// File: rtl/locker_keypad_entry.sv
// rtl/locker_keypad_entry.sv - keypad digit collection, submit handshake and lockout for the users checker
module locker_keypad_entry
  import locker_pkg::*;
#(
  parameter int DIGITS         = DEFAULT_DIGITS,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int RESP_WAIT      = 2
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          KeyValid,
  input  logic [KEY_W-1:0]              KeyCode,
  input  logic [1:0]                    UserSel,
  input  logic                          Access,
  input  logic                          Alarm,
  output logic [1:0]                    User,
  output logic [DIGITS*DIGIT_W-1:0]     PassIn,
  output logic                          Enter,
  output logic [$clog2(DIGITS+1)-1:0]   DigitCount,
  output logic                          Granted,
  output logic                          Denied,
  output logic                          Locked,
  output logic                          Busy
);

  localparam int PW = DIGITS * DIGIT_W;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int WW = (RESP_WAIT > 1) ? $clog2(RESP_WAIT) : 1;
  localparam logic [CW-1:0] FULL      = CW'(DIGITS);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RESP_WAIT - 1);

  state_t          state, state_n;
  logic [WW-1:0]   wait_cnt, wait_n;
  logic [PW-1:0]   pass_n;
  logic [CW-1:0]   count_n;
  logic [1:0]      user_n;
  logic            enter_n, granted_n, denied_n, locked_n, busy_n;
  logic            tmo_load, tmo_en, tmo_expired;

  locker_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (Clk),
    .rst    (Reset),
    .load   (tmo_load),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    pass_n    = PassIn;
    count_n   = DigitCount;
    user_n    = User;
    enter_n   = 1'b0;
    granted_n = 1'b0;
    denied_n  = 1'b0;
    tmo_load  = 1'b0;
    tmo_en    = 1'b0;

    // A raised alarm overrides everything, including a key in the same cycle.
    if (Alarm) begin
      state_n = ST_LOCKED;
    end else begin
      case (state)
        ST_IDLE, ST_COLLECT: begin
          tmo_en = (state == ST_COLLECT);
          if (KeyValid) begin
            if (is_digit(KeyCode)) begin
              tmo_load = 1'b1;
              if (DigitCount < FULL) begin
                pass_n  = {PassIn[PW-DIGIT_W-1:0], KeyCode[DIGIT_W-1:0]};
                count_n = DigitCount + 1'b1;
                state_n = ST_COLLECT;
              end
            end else begin
              case (KeyCode)
                KEY_CLEAR: begin
                  tmo_load = 1'b1;
                  pass_n   = '0;
                  count_n  = '0;
                  state_n  = ST_IDLE;
                end
                KEY_BKSP: begin
                  tmo_load = 1'b1;
                  pass_n   = PassIn >> DIGIT_W;
                  if (DigitCount != '0) count_n = DigitCount - 1'b1;
                  if (DigitCount <= CW'(1)) state_n = ST_IDLE;
                end
                KEY_ENTER: begin
                  tmo_load = 1'b1;
                  if (DigitCount == FULL) begin
                    user_n  = UserSel;
                    enter_n = 1'b1;
                    state_n = ST_SUBMIT;
                  end else begin
                    denied_n = 1'b1;
                    pass_n   = '0;
                    count_n  = '0;
                    state_n  = ST_IDLE;
                  end
                end
                default: ;
              endcase
            end
          end else if (tmo_expired) begin
            pass_n  = '0;
            count_n = '0;
            state_n = ST_IDLE;
          end
        end
        ST_SUBMIT: begin
          wait_n  = '0;
          state_n = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            granted_n = Access;
            denied_n  = !Access;
            pass_n    = '0;
            count_n   = '0;
            state_n   = ST_IDLE;
          end else begin
            wait_n = wait_cnt + 1'b1;
          end
        end
        ST_LOCKED: ;
        default: state_n = ST_IDLE;
      endcase
    end

    locked_n = (state_n == ST_LOCKED);
    busy_n   = (state_n == ST_SUBMIT) || (state_n == ST_WAIT) || (state_n == ST_LOCKED);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      PassIn     <= '0;
      DigitCount <= '0;
      User       <= '0;
      Enter      <= 1'b0;
      Granted    <= 1'b0;
      Denied     <= 1'b0;
      Locked     <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_n;
      PassIn     <= pass_n;
      DigitCount <= count_n;
      User       <= user_n;
      Enter      <= enter_n;
      Granted    <= granted_n;
      Denied     <= denied_n;
      Locked     <= locked_n;
      Busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_locker_keypad_entry.sv
// tb/tb_locker_keypad_entry.sv - self-checking bench for locker_keypad_entry
module tb_locker_keypad_entry;

  localparam int T  = 1000;
  localparam int RW = 2;
  localparam logic [4:0] K_CLR = 5'h10;
  localparam logic [4:0] K_BS  = 5'h11;
  localparam logic [4:0] K_ENT = 5'h12;

  logic        Clk, Reset, KeyValid, Access, Alarm;
  logic [4:0]  KeyCode;
  logic [1:0]  UserSel, User, DigitCount;
  logic [11:0] PassIn;
  logic        Enter, Granted, Denied, Locked, Busy;

  int n_cmp = 0;
  int n_bad = 0;
  int mq[$];

  locker_keypad_entry #(.DIGITS(3), .TIMEOUT_CYCLES(T), .RESP_WAIT(RW)) dut (
    .Clk(Clk), .Reset(Reset), .KeyValid(KeyValid), .KeyCode(KeyCode), .UserSel(UserSel),
    .Access(Access), .Alarm(Alarm), .User(User), .PassIn(PassIn), .Enter(Enter),
    .DigitCount(DigitCount), .Granted(Granted), .Denied(Denied), .Locked(Locked), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected password: held digits read most-significant first.
  function automatic logic [11:0] model_pass();
    logic [11:0] v;
    v = '0;
    foreach (mq[i]) v = (v << 4) | 12'(mq[i]);
    return v;
  endfunction

  task automatic press(input logic [4:0] code);
    KeyValid = 1'b1;
    KeyCode  = code;
    @(negedge Clk);
    KeyValid = 1'b0;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    mq.delete();
  endtask

  task automatic run_response(input logic acc, input string tag);
    Access = acc;
    for (int c = 0; c <= RW; c++) begin
      KeyValid = 1'b1;
      KeyCode  = 5'($urandom_range(0, 18));
      @(negedge Clk);
      if (c == 0) begin
        n_cmp++;
        if (Enter !== 1'b0) begin n_bad++; $display("FAIL %s enter_width: got %b expected 0", tag, Enter); end
      end
      if (c < RW) begin
        n_cmp++;
        if ({Granted, Denied} !== 2'b00) begin n_bad++; $display("FAIL %s early_result: got %b expected 00", tag, {Granted, Denied}); end
      end
    end
    KeyValid = 1'b0;
    n_cmp++;
    if ({Granted, Denied} !== {acc, !acc}) begin n_bad++; $display("FAIL %s result: got %b expected %b", tag, {Granted, Denied}, {acc, !acc}); end
    n_cmp++;
    if ({PassIn, DigitCount} !== 14'h0) begin n_bad++; $display("FAIL %s cleared: got %h/%0d expected 0/0", tag, PassIn, DigitCount); end
    @(negedge Clk);
    n_cmp++;
    if ({Granted, Denied, Busy} !== 3'b000) begin n_bad++; $display("FAIL %s pulse_end: got %b expected 000", tag, {Granted, Denied, Busy}); end
    Access = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    n_cmp++;
    if ({User, PassIn, Enter, DigitCount, Granted, Denied, Locked, Busy} !== 21'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", {User, PassIn, Enter, DigitCount, Granted, Denied, Locked, Busy});
    end
    Reset = 1'b0;
  endtask

  task automatic test_grant();
    UserSel = 2'd1;
    press(5'hF); press(5'h2); press(5'hA);
    n_cmp++;
    if (PassIn !== 12'hF2A || DigitCount !== 2'd3) begin n_bad++; $display("FAIL grant_collect: got %h/%0d expected f2a/3", PassIn, DigitCount); end
    press(K_ENT);
    UserSel = 2'd2;
    n_cmp++;
    if ({Enter, Busy, User, PassIn} !== {1'b1, 1'b1, 2'd1, 12'hF2A}) begin
      n_bad++; $display("FAIL grant_submit: got %b%b/%0d/%h expected 11/1/f2a", Enter, Busy, User, PassIn);
    end
    run_response(1'b1, "grant");
    n_cmp++;
    if (User !== 2'd1) begin n_bad++; $display("FAIL grant_user_hold: got %0d expected 1", User); end
  endtask

  task automatic test_backspace_short();
    press(5'h1); press(5'h2); press(K_BS); press(5'h3);
    n_cmp++;
    if (PassIn !== 12'h013 || DigitCount !== 2'd2) begin n_bad++; $display("FAIL bksp_value: got %h/%0d expected 013/2", PassIn, DigitCount); end
    press(K_ENT);
    n_cmp++;
    if ({Denied, Enter, PassIn, DigitCount} !== {1'b1, 1'b0, 14'h0}) begin
      n_bad++; $display("FAIL short_deny: got %b%b/%h/%0d expected 10/000/0", Denied, Enter, PassIn, DigitCount);
    end
    @(negedge Clk);
    n_cmp++;
    if ({Denied, Enter, Busy} !== 3'b000) begin n_bad++; $display("FAIL short_after: got %b expected 000", {Denied, Enter, Busy}); end
    UserSel = 2'd3;
    press(5'h4); press(5'h5); press(5'h6); press(K_ENT);
    n_cmp++;
    if ({Enter, User, PassIn} !== {1'b1, 2'd3, 12'h456}) begin n_bad++; $display("FAIL submit_456: got %b/%0d/%h expected 1/3/456", Enter, User, PassIn); end
    run_response(1'b0, "deny_456");
  endtask

  task automatic test_overflow_clear();
    press(5'hA); press(5'hB); press(5'hC); press(5'hD);
    n_cmp++;
    if (PassIn !== 12'hABC || DigitCount !== 2'd3) begin n_bad++; $display("FAIL overflow: got %h/%0d expected abc/3", PassIn, DigitCount); end
    press(K_CLR);
    n_cmp++;
    if ({PassIn, DigitCount} !== 14'h0) begin n_bad++; $display("FAIL clear_full: got %h/%0d expected 0/0", PassIn, DigitCount); end
    press(5'h7); press(5'h8); press(K_CLR);
    n_cmp++;
    if ({PassIn, DigitCount} !== 14'h0) begin n_bad++; $display("FAIL clear_mid: got %h/%0d expected 0/0", PassIn, DigitCount); end
    press(K_BS);
    n_cmp++;
    if ({PassIn, DigitCount} !== 14'h0) begin n_bad++; $display("FAIL bksp_empty: got %h/%0d expected 0/0", PassIn, DigitCount); end
  endtask

  task automatic test_timeout();
    press(5'h3); press(5'h9);
    repeat (T - 1) @(negedge Clk);
    n_cmp++;
    if (PassIn !== 12'h039 || DigitCount !== 2'd2) begin n_bad++; $display("FAIL timeout_before: got %h/%0d expected 039/2", PassIn, DigitCount); end
    @(negedge Clk);
    n_cmp++;
    if ({PassIn, DigitCount, Granted, Denied} !== 16'h0) begin
      n_bad++; $display("FAIL timeout_expire: got %h/%0d/%b%b expected 0/0/00", PassIn, DigitCount, Granted, Denied);
    end
    press(5'h3); press(5'h9);
    repeat (T - 1) @(negedge Clk);
    press(5'h7);
    n_cmp++;
    if (PassIn !== 12'h397 || DigitCount !== 2'd3) begin n_bad++; $display("FAIL timeout_key_wins: got %h/%0d expected 397/3", PassIn, DigitCount); end
    press(K_CLR);
  endtask

  task automatic test_reset_submit();
    press(5'h1); press(5'h2); press(5'h3); press(K_ENT);
    n_cmp++;
    if (Enter !== 1'b1) begin n_bad++; $display("FAIL rst_submit_enter: got %b expected 1", Enter); end
    #2 Reset = 1'b1;
    #1;
    n_cmp++;
    if ({Enter, Busy, PassIn, DigitCount} !== 16'h0) begin
      n_bad++; $display("FAIL rst_async: got %b%b/%h/%0d expected 00/0/0", Enter, Busy, PassIn, DigitCount);
    end
    @(negedge Clk);
    Reset = 1'b0;
    press(5'h5);
    n_cmp++;
    if (PassIn !== 12'h005 || DigitCount !== 2'd1 || Busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_idle: got %h/%0d/%b expected 005/1/0", PassIn, DigitCount, Busy);
    end
    press(K_CLR);
  endtask

  task automatic test_random();
    int r;
    logic [4:0] code;
    logic [1:0] us;
    logic full, exp_enter, exp_deny;
    apply_reset();
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      code = 5'($urandom_range(0, 15));
      else if (r < 65) code = K_BS;
      else if (r < 72) code = K_CLR;
      else if (r < 92) code = K_ENT;
      else             code = 5'($urandom_range(19, 31));
      us = 2'($urandom_range(0, 3));
      UserSel = us;
      full = (mq.size() == 3);
      exp_enter = (code == K_ENT) && full;
      exp_deny  = (code == K_ENT) && !full;
      if (code < 5'h10) begin
        if (mq.size() < 3) mq.push_back(int'(code));
      end else if (code == K_BS) begin
        if (mq.size() > 0) void'(mq.pop_back());
      end else if (code == K_CLR || exp_deny) begin
        mq.delete();
      end
      press(code);
      n_cmp++;
      if (PassIn !== model_pass() || DigitCount !== 2'(mq.size())) begin
        n_bad++; $display("FAIL rand_buffer it%0d: got %h/%0d expected %h/%0d", it, PassIn, DigitCount, model_pass(), mq.size());
      end
      n_cmp++;
      if ({Enter, Denied} !== {exp_enter, exp_deny}) begin
        n_bad++; $display("FAIL rand_pulse it%0d: got %b expected %b", it, {Enter, Denied}, {exp_enter, exp_deny});
      end
      if (exp_enter) begin
        n_cmp++;
        if (User !== us) begin n_bad++; $display("FAIL rand_user it%0d: got %0d expected %0d", it, User, us); end
        run_response(1'($urandom_range(0, 1)), "rand_resp");
        mq.delete();
      end
    end
  endtask

  task automatic test_alarm_lockout();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      press(5'h1); press(5'h1); press(5'(k));
      press(K_ENT);
      n_cmp++;
      if (Enter !== 1'b1) begin n_bad++; $display("FAIL alarm_enter%0d: got %b expected 1", k, Enter); end
      if (k < 2) begin
        run_response(1'b0, "alarm_deny");
      end else begin
        Access = 1'b0;
        repeat (RW) @(negedge Clk);
        Alarm = 1'b1;
        @(negedge Clk);
        Alarm = 1'b0;
        n_cmp++;
        if ({Locked, Busy, Granted, Denied} !== 4'b1100) begin
          n_bad++; $display("FAIL alarm_lock: got %b expected 1100", {Locked, Busy, Granted, Denied});
        end
      end
    end
    press(K_CLR); press(5'h4); press(K_ENT);
    repeat (RW + 2) @(negedge Clk);
    n_cmp++;
    if ({Locked, Enter, Granted, Denied} !== 4'b1000) begin
      n_bad++; $display("FAIL lock_ignores_keys: got %b expected 1000", {Locked, Enter, Granted, Denied});
    end
    apply_reset();
    n_cmp++;
    if ({User, PassIn, Enter, DigitCount, Granted, Denied, Locked, Busy} !== 21'h0) begin
      n_bad++; $display("FAIL lock_reset: got %h expected 0", {User, PassIn, Enter, DigitCount, Granted, Denied, Locked, Busy});
    end
    KeyValid = 1'b1; KeyCode = 5'h6; Alarm = 1'b1;
    @(negedge Clk);
    KeyValid = 1'b0; Alarm = 1'b0;
    n_cmp++;
    if (Locked !== 1'b1 || DigitCount !== 2'd0) begin
      n_bad++; $display("FAIL alarm_priority: got %b/%0d expected 1/0", Locked, DigitCount);
    end
    apply_reset();
  endtask

  initial begin
    Reset = 1'b1; KeyValid = 1'b0; KeyCode = '0; UserSel = '0; Access = 1'b0; Alarm = 1'b0;
    test_reset();
    test_grant();
    test_backspace_short();
    test_overflow_clear();
    test_timeout();
    test_reset_submit();
    test_random();
    test_alarm_lockout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
